// File: rtl/lcd_id_probe_ctrl.sv
// LCD power-up / re-probe sequencer: releases the RGB bus, debounces the panel ID
// straps, drives the divider ID, then walks panel reset release and backlight enable.
module lcd_id_probe_ctrl #(
    parameter logic [15:0] SETTLE_CYC     = 16'd1000,
    parameter logic [7:0]  STABLE_N       = 8'd16,
    parameter logic [15:0] TIMEOUT_CYC    = 16'd4000,
    parameter logic [15:0] CLK_SETTLE_CYC = 16'd64,
    parameter logic [15:0] RST_CYC        = 16'd5000,
    parameter logic [15:0] WAKE_CYC       = 16'd5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  strap_in,
    input  logic        reprobe,
    output logic [15:0] lcd_id,
    output logic        id_valid,
    output logic        id_fault,
    output logic        rgb_oe,
    output logic        lcd_rst_n,
    output logic        lcd_bl
);

    typedef enum logic [2:0] {
        S_SETTLE, S_SAMPLE, S_APPLY, S_RST, S_WAKE, S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [7:0]    stable_q, stable_d;
    logic [2:0]    prev_q, prev_d;
    logic [1:0][2:0] sync_q;
    logic [15:0]   lcd_id_q, lcd_id_d;
    logic          id_fault_q, id_fault_d;
    logic          id_valid_q, id_valid_d;
    logic          rgb_oe_q, rgb_oe_d;
    logic          lcd_rst_n_q, lcd_rst_n_d;
    logic          lcd_bl_q, lcd_bl_d;
    logic [2:0]    strap_s;
    logic          accept, timeout, run_d;

    assign strap_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            state_q     <= S_SETTLE;
            cnt_q       <= '0;
            stable_q    <= '0;
            prev_q      <= '0;
            lcd_id_q    <= '0;
            id_fault_q  <= 1'b0;
            id_valid_q  <= 1'b0;
            rgb_oe_q    <= 1'b0;
            lcd_rst_n_q <= 1'b0;
            lcd_bl_q    <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], strap_in};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            prev_q      <= prev_d;
            lcd_id_q    <= lcd_id_d;
            id_fault_q  <= id_fault_d;
            id_valid_q  <= id_valid_d;
            rgb_oe_q    <= rgb_oe_d;
            lcd_rst_n_q <= lcd_rst_n_d;
            lcd_bl_q    <= lcd_bl_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stable_d   = stable_q;
        prev_d     = prev_q;
        lcd_id_d   = lcd_id_q;
        id_fault_d = id_fault_q;
        accept     = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            S_SETTLE: if (cnt_q == SETTLE_CYC - 16'd1) state_d = S_SAMPLE;
            S_SAMPLE: begin
                if (strap_s == prev_q) begin
                    stable_d = stable_q + 8'd1;
                end else begin
                    stable_d = 8'd0;
                    prev_d   = strap_s;
                end
                accept  = (strap_s == prev_q) && (stable_d == STABLE_N - 8'd1);
                timeout = (cnt_q == TIMEOUT_CYC - 16'd1);
                // acceptance takes priority over a coincident timeout
                if (accept) begin
                    state_d = S_APPLY;
                    case (prev_q)
                        3'b000, 3'b001, 3'b010, 3'b101: begin
                            lcd_id_d   = {13'd0, prev_q};
                            id_fault_d = 1'b0;
                        end
                        default: begin
                            lcd_id_d   = 16'd0;
                            id_fault_d = 1'b1;
                        end
                    endcase
                end else if (timeout) begin
                    state_d    = S_APPLY;
                    lcd_id_d   = 16'd0;
                    id_fault_d = 1'b1;
                end
            end
            S_APPLY:  if (cnt_q == CLK_SETTLE_CYC - 16'd1) state_d = S_RST;
            S_RST:    if (cnt_q == RST_CYC - 16'd1) state_d = S_WAKE;
            S_WAKE:   if (cnt_q == WAKE_CYC - 16'd1) state_d = S_RUN;
            S_RUN:    if (reprobe) state_d = S_SETTLE;
            default:  state_d = S_SETTLE;
        endcase

        if (state_d == S_SAMPLE && state_q != S_SAMPLE) begin
            prev_d   = 3'b000;
            stable_d = 8'd0;
        end

        if (state_d != state_q)    cnt_d = 16'd0;
        else if (state_q == S_RUN) cnt_d = cnt_q;
        else                       cnt_d = cnt_q + 16'd1;

        // outputs are decoded from the next state so they change on the entry edge
        run_d       = (state_d == S_RUN);
        id_valid_d  = run_d;
        rgb_oe_d    = run_d;
        lcd_bl_d    = run_d;
        lcd_rst_n_d = run_d || (state_d == S_WAKE);
    end

    assign lcd_id    = lcd_id_q;
    assign id_valid  = id_valid_q;
    assign id_fault  = id_fault_q;
    assign rgb_oe    = rgb_oe_q;
    assign lcd_rst_n = lcd_rst_n_q;
    assign lcd_bl    = lcd_bl_q;

endmodule

// File: doc/lcd_id_probe_ctrl.md
Name: lcd_id_probe_ctrl

Overview:
- Power-up/re-probe sequencer for the RGB LCD path.
- Releases the panel data bus and samples the panel's ID strap pins (R7/G7/B7), then latches a debounced ID code.
- Drives the 16-bit ID consumed by the LCD pixel-clock divider, waits for the selected clock to settle, and only then runs the panel reset release and bus/backlight enable sequence.

Parameters:
- SETTLE_CYC, 16'd1000, cycles bus is held released (tri-stated) before sampling starts.
- STABLE_N, 8'd16, consecutive identical strap samples required to accept an ID.
- TIMEOUT_CYC, 16'd4000, max sample-phase cycles before fault fallback.
- CLK_SETTLE_CYC, 16'd64, cycles after ID latch before panel reset release (divider settle).
- RST_CYC, 16'd5000, panel reset-low hold cycles in reset phase.
- WAKE_CYC, 16'd5000, cycles after reset release before bus/backlight enable.
- Constraint: all cycle parameters ≥1; STABLE_N ≥2.

Ports:
- clk  in  1  system clock (50 MHz domain feeding the divider).
- rst_n  in  1  asynchronous active-low reset.
- strap_in  in  3  {lcd_rgb[7], lcd_rgb[15], lcd_rgb[23]} = {M2,M1,M0}; asynchronous pad inputs.
- reprobe  in  1  single-cycle request to redo the full sequence.
- lcd_id  out  16  ID code to clock divider.
- id_valid  out  1  high when the sequence is complete and the panel is running.
- id_fault  out  1  high when the last probe timed out or returned an unsupported code.
- rgb_oe  out  1  panel data bus output enable; 0 = released for strap read.
- lcd_rst_n  out  1  panel reset, active low.
- lcd_bl  out  1  backlight enable.

Behaviour:
- Reset values:
  - lcd_id=16'd0, id_valid=0, id_fault=0, rgb_oe=0, lcd_rst_n=0, lcd_bl=0.
  - FSM=S_SETTLE, all counters=0.
- strap_in passes through a 2-flop synchronizer (reset 0) before any use.
- One shared 16-bit phase counter. It clears on every state entry. A state with parameter N occupies exactly N cycles.
- S_SETTLE:
  - rgb_oe=0, lcd_rst_n=0, lcd_bl=0.
  - After SETTLE_CYC cycles, go to S_SAMPLE.
- S_SAMPLE: each cycle compare the synchronized strap with prev_strap.
  - Equal: stable_cnt+1.
  - Different: stable_cnt=0 and prev_strap=new value.
  - prev_strap is cleared to 0 on S_SAMPLE entry.
  - The cycle stable_cnt reaches STABLE_N-1: latch prev_strap, then go to S_APPLY.
  - If the phase counter reaches TIMEOUT_CYC-1 without acceptance: latch code 0, set id_fault=1, go to S_APPLY.
  - If both conditions occur in the same cycle, acceptance wins.
- Code mapping at latch:
  - 3'b000→0, 3'b001→1, 3'b010→2, 3'b101→5.
  - lcd_id={13'd0, code}.
  - Any other code (3,4,6,7) → lcd_id=0 and id_fault=1.
  - A valid code clears id_fault.
  - lcd_id updates on the clock edge leaving S_SAMPLE and is otherwise stable.
- S_APPLY: hold CLK_SETTLE_CYC cycles with lcd_rst_n=0, then go to S_RST.
- S_RST: lcd_rst_n=0 for RST_CYC cycles, then go to S_WAKE.
- S_WAKE: lcd_rst_n=1 for WAKE_CYC cycles, then go to S_RUN.
- S_RUN:
  - rgb_oe=1, lcd_bl=1, lcd_rst_n=1, id_valid=1.
  - All four assert on the same edge entering S_RUN.
- reprobe handling:
  - Sampled only in S_RUN; ignored in all other states.
  - On the next edge: id_valid=0, lcd_bl=0, rgb_oe=0, lcd_rst_n=0, go to S_SETTLE.
  - lcd_id and id_fault hold their old values until the next latch.
- Asynchronous reset at any point returns immediately to the reset values; no partial sequence is retained.
- All outputs are registered; no combinational path from input to output.

Test Plan:
- Use SETTLE_CYC=8, STABLE_N=4, TIMEOUT_CYC=32, CLK_SETTLE_CYC=4, RST_CYC=10, WAKE_CYC=6 throughout.
- Scenario 1: strap=3'b001 held from reset → lcd_id=16'd1 after the S_SAMPLE exit; lcd_rst_n rises 14 cycles later; id_valid, rgb_oe and lcd_bl rise together 6 cycles after that; id_fault=0.
- Scenario 2: strap=3'b101 with a single-cycle glitch to 3'b100 mid-sample → stable count restarts; final lcd_id=16'd5, id_fault=0.
- Scenario 3: strap toggles 3'b000/3'b010 every 2 cycles → timeout at 32 sample cycles; lcd_id=0, id_fault=1; sequence still completes to id_valid=1.
- Scenario 4: strap=3'b110 stable → lcd_id=0, id_fault=1, id_valid=1 at end.
- Scenario 5: in S_RUN with lcd_id=1, change strap to 3'b010 and pulse reprobe → next cycle id_valid=0, lcd_bl=0, rgb_oe=0, lcd_rst_n=0; lcd_id stays 1 until the new latch, then becomes 2. Also pulse reprobe during S_WAKE → no effect.
- Scenario 6: assert rst_n=0 during S_RST → all outputs return to reset values asynchronously; after release, a full sequence restarts from S_SETTLE.
